// File: rtl/push_repeat_ctrl.sv
// Debounced two-button command controller: synchronizes active-low buttons, arbitrates,
// and emits single-cycle up/down strobes with auto-repeat while the button is held.
module push_repeat_ctrl #(
    parameter int DEB_CYC = 500000,
    parameter int RPT_DLY = 25000000,
    parameter int RPT_PER = 5000000,
    parameter int TW      = 25
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Push,
    output logic       o_Up,
    output logic       o_Dn,
    output logic       o_Busy,
    output logic [2:0] o_State
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        HOLD_DLY = 3'd2,
        REPEAT   = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [TW-1:0] DEB_LAST = TW'(DEB_CYC - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DLY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(RPT_PER - 1);

    logic [1:0]    sync1_q;
    logic [1:0]    s_push_q;
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic          sel_q;
    logic          up_q;
    logic          dn_q;
    logic          busy_q;
    logic          key_up;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q  <= 2'b11;
            s_push_q <= 2'b11;
        end else begin
            sync1_q  <= i_Push;
            s_push_q <= sync1_q;
        end
    end

    // sel_q: 0 selects the up button (bit 1), 1 selects the down button (bit 0).
    assign key_up = sel_q ? s_push_q[0] : s_push_q[1];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            sel_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            up_q <= 1'b0;
            dn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (!s_push_q[1]) begin
                        sel_q   <= 1'b0;
                        state_q <= DEBOUNCE;
                        busy_q  <= 1'b1;
                    end else if (!s_push_q[0]) begin
                        sel_q   <= 1'b1;
                        state_q <= DEBOUNCE;
                        busy_q  <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (key_up) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (timer_q == DEB_LAST) begin
                        timer_q <= '0;
                        state_q <= HOLD_DLY;
                        up_q    <= ~sel_q;
                        dn_q    <= sel_q;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                HOLD_DLY: begin
                    if (key_up) begin
                        timer_q <= '0;
                        state_q <= RELEASE;
                    end else if (timer_q == DLY_LAST) begin
                        timer_q <= '0;
                        state_q <= REPEAT;
                        up_q    <= ~sel_q;
                        dn_q    <= sel_q;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                REPEAT: begin
                    if (key_up) begin
                        timer_q <= '0;
                        state_q <= RELEASE;
                    end else if (timer_q == PER_LAST) begin
                        timer_q <= '0;
                        up_q    <= ~sel_q;
                        dn_q    <= sel_q;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RELEASE: begin
                    // Any bounce back to pressed restarts the release qualification window.
                    if (!key_up) begin
                        timer_q <= '0;
                    end else if (timer_q == DEB_LAST) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Up    = up_q;
    assign o_Dn    = dn_q;
    assign o_Busy  = busy_q;
    assign o_State = state_q;

endmodule

// File: tb/tb_push_repeat_ctrl.sv
// Directed bench for push_repeat_ctrl with short timing constants: a vector table of
// button waveforms with expected strobe cycles, plus reset sequences.
module tb_push_repeat_ctrl;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] push = 2'b11;
    logic       up;
    logic       dn;
    logic       busy;
    logic [2:0] st;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    push_repeat_ctrl #(
        .DEB_CYC(DEB),
        .RPT_DLY(DLY),
        .RPT_PER(PER),
        .TW     (4)
    ) dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .i_Push (push),
        .o_Up   (up),
        .o_Dn   (dn),
        .o_Busy (busy),
        .o_State(st)
    );

    // Raw push waveform: p1 for cycles [0,n1), p2 for [s2,s2+n2), else released.
    typedef struct {
        string       name;
        logic [1:0]  p1;
        int          n1;
        logic [1:0]  p2;
        int          s2;
        int          n2;
        int          run;
        logic [63:0] up_m;
        logic [63:0] dn_m;
        int          idle_at;
        bit          rel;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [63:0] b(input int k);
        return 64'd1 << k;
    endfunction

    function automatic vec_t mk(input string n, input logic [1:0] p1, input int n1,
                                input logic [1:0] p2, input int s2, input int n2,
                                input int run, input logic [63:0] um, input logic [63:0] dm,
                                input int idle_at, input bit rel);
        vec_t v;
        v.name = n; v.p1 = p1; v.n1 = n1; v.p2 = p2; v.s2 = s2; v.n2 = n2;
        v.run = run; v.up_m = um; v.dn_m = dm; v.idle_at = idle_at; v.rel = rel;
        return v;
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name, input int c);
        chk({name, ".up"}, c, 32'(up), 0);
        chk({name, ".dn"}, c, 32'(dn), 0);
        chk({name, ".busy"}, c, 32'(busy), 0);
        chk({name, ".state"}, c, 32'(st), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int  last_st = -1;
        int  last_busy = -1;
        bit  saw_rel = 1'b0;
        for (int c = 0; c < v.run; c++) begin
            step();
            chk({v.name, ".up"}, c, 32'(up), 32'(v.up_m[c]));
            chk({v.name, ".dn"}, c, 32'(dn), 32'(v.dn_m[c]));
            if (st != 3'd0) last_st = c;
            if (busy) last_busy = c;
            if (st == 3'd4) saw_rel = 1'b1;
            if (c < v.n1) push = v.p1;
            else if (c >= v.s2 && c < v.s2 + v.n2) push = v.p2;
            else push = 2'b11;
        end
        chk({v.name, ".state_idle_at"}, v.run, 32'(last_st + 1), 32'(v.idle_at));
        chk({v.name, ".busy_idle_at"}, v.run, 32'(last_busy + 1), 32'(v.idle_at));
        chk({v.name, ".release_seen"}, v.run, 32'(saw_rel), 32'(v.rel));
        $display("[TB] vector %s done", v.name);
    endtask

    initial begin
        vecs[0] = mk("short_up4",    2'b01, 4,  2'b11, 0,  0,  14, 64'd0, 64'd0, 7,  1'b0);
        vecs[1] = mk("glitch_dn",    2'b10, 3,  2'b11, 0,  0,  12, 64'd0, 64'd0, 6,  1'b0);
        vecs[2] = mk("edge_up5",     2'b01, 5,  2'b11, 0,  0,  18, b(7),  64'd0, 12, 1'b1);
        vecs[3] = mk("single_up",    2'b01, 8,  2'b11, 0,  0,  22, b(7),  64'd0, 15, 1'b1);
        vecs[4] = mk("repeat_up",    2'b01, 29, 2'b11, 0,  0,  42,
                     b(7) | b(17) | b(20) | b(23) | b(26) | b(29), 64'd0, 36, 1'b1);
        vecs[5] = mk("repeat_dn",    2'b10, 20, 2'b11, 0,  0,  32, 64'd0,
                     b(7) | b(17) | b(20), 27, 1'b1);
        vecs[6] = mk("both_up_wins", 2'b00, 8,  2'b11, 0,  0,  22, b(7),  64'd0, 15, 1'b1);
        vecs[7] = mk("dn_ignored",   2'b01, 8,  2'b10, 8,  2,  22, b(7),  64'd0, 15, 1'b1);
        vecs[8] = mk("dn_fresh",     2'b00, 8,  2'b10, 8,  12, 35, b(7),  b(20), 27, 1'b1);
        vecs[9] = mk("rel_bounce",   2'b01, 8,  2'b01, 12, 1,  26, b(7),  64'd0, 19, 1'b1);

        // Reset held with buttons released.
        for (int c = 0; c < 3; c++) begin
            step();
            chk_zero("reset_hold", c);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_zero("reset_after", c);
        end
        $display("[TB] reset sequence done");

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset in the middle of auto-repeat, up held throughout.
        for (int c = 0; c <= 20; c++) begin
            step();
            chk("midrst.up", c, 32'(up), 32'(c == 7 || c == 17 || c == 20));
            chk("midrst.dn", c, 32'(dn), 0);
            push = 2'b01;
        end
        step();
        chk("midrst.state_pre", 21, 32'(st), 3);
        rst = 1'b1;
        #1;
        chk_zero("midrst.async", 21);
        step();
        chk_zero("midrst.held", 22);
        step();
        chk_zero("midrst.held", 23);
        rst = 1'b0;
        for (int c = 24; c <= 50; c++) begin
            step();
            chk("midrst.up", c, 32'(up),
                32'(c == 30 || c == 40 || c == 43 || c == 46 || c == 49));
            chk("midrst.dn", c, 32'(dn), 0);
        end
        push = 2'b11;
        begin
            int n = 0;
            while (st != 3'd0 && n < 40) begin
                step();
                n++;
            end
            chk("midrst.return_idle", 51 + n, 32'(st), 0);
        end
        $display("[TB] mid-repeat reset sequence done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
